fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main decoder in the MIPS core.
- Owns the PC register and talks to a variable-latency instruction memory over a req/ready handshake.
- Holds the fetched word in an instruction register. instr[31:26] feeds the decoder's op input.
- Computes the next PC from decoder/ALU outcomes (branch, bne, jump, zero) when the datapath signals it has consumed the instruction (advance).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  input  1  core clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- imem_req  output  1  fetch request, held high until accepted by imem_ready
- imem_addr  output  32  fetch address; equals pc while imem_req is high
- imem_ready  input  1  imem_rdata is valid this cycle (response strobe)
- imem_rdata  input  32  instruction word from memory
- instr  output  32  registered instruction; op field is instr[31:26]
- instr_valid  output  1  instr holds a fetched, not-yet-consumed instruction
- pc  output  32  address of instr
- pcplus4  output  32  pc + 4, modulo 2^32
- advance  input  1  datapath consumes instr this cycle; control inputs valid
- branch  input  1  decoder BEQ control
- bne  input  1  decoder BNE control
- jump  input  1  decoder J control
- zero  input  1  ALU zero flag for the current instr

Behaviour:
- FSM states: IDLE, FETCH, HOLD. State, pc and instr are flops with asynchronous reset.
- Reset, while asserted and on release:
  - state=IDLE, pc=RESET_PC, instr=32'h0000_0000.
  - instr_valid=0, imem_req=0; imem_addr=pc=RESET_PC; pcplus4=RESET_PC+4.
- IDLE: unconditionally go to FETCH next cycle. imem_ready is ignored.
- FETCH: imem_req=1, imem_addr=pc.
  - If imem_ready: instr<=imem_rdata, go to HOLD.
  - Otherwise stay; the request stays stable, with no timeout.
- HOLD: instr_valid=1, imem_req=0, imem_ready ignored.
  - If advance: pc<=next_pc, instr_valid drops next cycle, go to FETCH.
  - Otherwise hold pc and instr unchanged indefinitely.
- Throughput: minimum 2 cycles per instruction (imem_ready in the first FETCH cycle, advance in the first HOLD cycle). First instruction is valid 2 cycles after reset release at the earliest.
- next_pc, combinational from instr, pc and the control inputs:
  - signimm = sign-extend instr[15:0] to 32 bits.
  - btarget = pcplus4 + (signimm << 2), modulo 2^32.
  - jtarget = {pcplus4[31:28], instr[25:0], 2'b00}.
  - taken = (branch & zero) | (bne & ~zero).
  - Priority: jump → jtarget; else taken → btarget; else pcplus4.
  - branch and bne both high: taken if either condition holds (no X propagation).
- Control inputs are sampled only in HOLD with advance=1. Otherwise don't-care; X on them must not corrupt state.
- advance while not in HOLD: ignored.
- imem_ready with imem_req=0: ignored, instr unchanged.
- Wrap-around: pc=32'hFFFF_FFFC → pcplus4=32'h0000_0000; sequential next pc is 0.
- Backward branch: instr[15:0]=16'hFFFF gives btarget=pc.
- Reset mid-FETCH or mid-HOLD: immediate return to reset values. A late imem_ready after release lands in IDLE and is dropped.
- pc[1:0] is always 00 by construction; no misalignment handling.

Decomposition:
- Shared package mips_pkg:
  - fetch_state_t enum {IDLE, FETCH, HOLD}.
  - RESET_PC default constant.
  - localparams for instruction field slices (OP=31:26, IMM=15:0, JIDX=25:0).
- One combinational sub-module, pc_next_logic: inputs pc, instr, branch, bne, jump, zero; outputs pcplus4, next_pc.
- FSM, PC register and instruction register stay in fetch_unit.

Test Plan:
- Reset then sequential fetch:
  - Stimulus: release reset; imem_ready=1 with rdata=32'h2008_0005 (ADDI) in the first FETCH cycle; advance=1 with all controls 0.
  - Response: instr_valid high 2 cycles after release; pc goes 0→4; next imem_addr=32'h4.
- Memory stall:
  - Stimulus: imem_ready held low 5 cycles in FETCH.
  - Response: imem_req=1 and imem_addr constant throughout; instr_valid=0; capture on the 6th cycle.
- BEQ:
  - Taken: pc=32'h10, instr=32'h1000_0003, branch=1, zero=1, advance → pc=32'h20.
  - Not taken: same with zero=0 → pc=32'h14.
  - BNE with zero=0, instr[15:0]=16'hFFFF → pc=32'h10.
- Jump:
  - Stimulus: pc=32'h4000_0000, instr=32'h0800_0100, jump=1 plus branch=1, zero=1.
  - Response: pc=32'h4000_0400 (jump wins).
- Wrap and hold:
  - Stimulus: RESET_PC=32'hFFFF_FFFC; advance held 0 for 3 HOLD cycles, then advance with no control.
  - Response: instr, pc and instr_valid stable during hold; pc=0 afterwards.
- Reset mid-operation:
  - Stimulus: assert reset in FETCH (imem_req=1), then pulse imem_ready=1 in the first post-reset cycle.
  - Response: outputs reach reset values immediately; the response is ignored; the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM states, reset PC and instruction field slices.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 26;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;
  localparam int JIDX_MSB = 25;
  localparam int JIDX_LSB = 0;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: sequential, conditional branch or jump target.
module pc_next_logic
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic        bne,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] pcplus4,
  output logic [31:0] next_pc
);

  logic [31:0] signimm;
  logic [31:0] btarget;
  logic [31:0] jtarget;
  logic        taken;
  logic        unused_op;

  assign pcplus4 = pc + 32'd4;
  assign signimm = {{16{instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB]};
  assign btarget = pcplus4 + (signimm << 2);
  assign jtarget = {pcplus4[31:28], instr[JIDX_MSB:JIDX_LSB], 2'b00};

  // BEQ and BNE may both be set; either satisfied condition takes the branch.
  assign taken = (branch & zero) | (bne & ~zero);

  // The opcode is decoded downstream; only the control outcomes matter here.
  assign unused_op = ^instr[OP_MSB:OP_LSB];

  always_comb begin
    next_pc = pcplus4;
    if (jump) begin
      next_pc = jtarget;
    end else if (taken) begin
      next_pc = btarget;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, instruction register and imem req/ready FSM.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  input  logic        advance,
  input  logic        branch,
  input  logic        bne,
  input  logic        jump,
  input  logic        zero
);

  fetch_state_t state;
  logic [31:0]  next_pc;

  pc_next_logic u_pc_next (
    .pc      (pc),
    .instr   (instr),
    .branch  (branch),
    .bne     (bne),
    .jump    (jump),
    .zero    (zero),
    .pcplus4 (pcplus4),
    .next_pc (next_pc)
  );

  assign imem_addr = pc;

  // imem_req and instr_valid are registered alongside the state so they
  // never glitch on the memory interface.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 32'h0000_0000;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            instr       <= imem_rdata;
            state       <= HOLD;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        HOLD: begin
          // Control inputs are only trusted here, when the datapath consumes instr.
          if (advance) begin
            pc          <= next_pc;
            state       <= FETCH;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with directed corner cases up front.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        advance, branch, bne, jump, zero;

  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, pc, pcplus4;
  logic        j_imem_req, j_instr_valid;
  logic [31:0] j_imem_addr, j_instr, j_pc, j_pcplus4;

  fetch_unit dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .pcplus4(pcplus4), .advance(advance),
    .branch(branch), .bne(bne), .jump(jump), .zero(zero)
  );

  // Second instance at a high reset PC, driven by the same inputs, to reach jump targets in region 4.
  fetch_unit #(.RESET_PC(32'h4000_0000)) dut_j (
    .clk(clk), .reset(reset), .imem_req(j_imem_req), .imem_addr(j_imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(j_instr),
    .instr_valid(j_instr_valid), .pc(j_pc), .pcplus4(j_pcplus4), .advance(advance),
    .branch(branch), .bne(bne), .jump(jump), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          cyc0;
  logic [31:0] model_pc;
  logic [31:0] model_instr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural next-PC rule expressed with plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] ins,
                                           input logic b, input logic n, input logic j,
                                           input logic z);
    logic [31:0] p4;
    int          simm;
    p4   = p + 32'd4;
    simm = $signed(ins[15:0]);
    if (j) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
    if ((b && z) || (n && !z)) return p4 + 32'(simm * 4);
    return p4;
  endfunction

  task automatic idle_inputs(input bit noisy);
    advance    = 1'b0;
    branch     = 1'($urandom);
    bne        = 1'($urandom);
    jump       = 1'($urandom);
    zero       = 1'($urandom);
    imem_rdata = $urandom;
    imem_ready = noisy ? 1'($urandom) : 1'b0;
  endtask

  task automatic reset_dut(input bit late_ready);
    reset = 1'b1;
    idle_inputs(0);
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pcplus4", pcplus4, 32'h4);
    chk("rst_instr", instr, 32'h0);
    chk("rst_j_pc", j_pc, 32'h4000_0000);
    @(negedge clk);
    reset = 1'b0;
    cyc0  = cyc;
    if (late_ready) begin
      imem_ready = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
    end
    model_pc = 32'h0;
    sb.delete();
  endtask

  task automatic do_fetch(input int lat, input logic [31:0] w);
    int          n;
    logic [31:0] addr0;
    n = 0;
    while (!imem_req && n < 10) begin
      @(negedge clk);
      idle_inputs(0);
      n++;
    end
    if (!imem_req) chk("fetch_timeout", imem_req, 1);
    chk("fetch_addr", imem_addr, model_pc);
    addr0 = imem_addr;
    for (int i = 0; i < lat; i++) begin
      chk("stall_req", imem_req, 1);
      chk("stall_addr", imem_addr, addr0);
      chk("stall_valid", instr_valid, 0);
      @(negedge clk);
      idle_inputs(0);
    end
    chk("accept_req", imem_req, 1);
    imem_ready  = 1'b1;
    imem_rdata  = w;
    model_instr = w;
    sb.push_back('{pc: model_pc, instr: w});
    @(negedge clk);
    idle_inputs(1);
  endtask

  task automatic do_hold(input int w, input bit b, input bit n, input bit j, input bit z);
    for (int i = 0; i < w; i++) begin
      chk("hold_valid", instr_valid, 1);
      chk("hold_req", imem_req, 0);
      @(negedge clk);
      idle_inputs(1);
    end
    chk("adv_valid", instr_valid, 1);
    advance  = 1'b1;
    branch   = b;
    bne      = n;
    jump     = j;
    zero     = z;
    model_pc = ref_next(model_pc, model_instr, b, n, j, z);
    @(negedge clk);
    idle_inputs(0);
    chk("adv_valid_drop", instr_valid, 0);
  endtask

  // Monitor: each new instr_valid presentation is matched against the scoreboard.
  initial begin : monitor
    exp_t cur;
    bit   prev;
    prev = 0;
    cur  = '{pc: 32'h0, instr: 32'h0};
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 0;
      end else begin
        if (instr_valid && !prev) begin
          if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 1);
          end else begin
            cur = sb.pop_front();
            chk("mon_pc", pc, cur.pc);
            chk("mon_instr", instr, cur.instr);
            chk("mon_pcplus4", pcplus4, cur.pc + 32'd4);
          end
        end else if (instr_valid) begin
          chk("mon_hold_pc", pc, cur.pc);
          chk("mon_hold_instr", instr, cur.instr);
        end
        prev = instr_valid;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] w;
    reset = 1'b1;
    idle_inputs(0);
    model_pc = 32'h0;
    repeat (2) @(negedge clk);

    // Jump priority over a taken branch, seen in the high-region instance.
    reset_dut(0);
    do_fetch(0, 32'h0800_0100);
    chk("first_valid_lat", 32'(cyc - cyc0), 2);
    do_hold(0, 1, 0, 1, 1);
    chk("jump_j_pc", j_pc, 32'h4000_0400);
    chk("jump_pc", pc, 32'h0000_0400);

    // Sequential fetch from reset.
    reset_dut(0);
    do_fetch(0, 32'h2008_0005);
    chk("seq_lat", 32'(cyc - cyc0), 2);
    do_hold(0, 0, 0, 0, 0);
    chk("seq_addr", imem_addr, 32'h4);

    // Memory stall, then walk to pc=0x10.
    do_fetch(5, 32'h0000_0020);
    do_hold(0, 0, 0, 0, 0);
    do_fetch(0, 32'h0000_0020);
    do_hold(0, 0, 0, 0, 0);
    do_fetch(0, 32'h0000_0020);
    do_hold(0, 0, 0, 0, 0);
    chk("walk_pc", pc, 32'h10);

    do_fetch(1, 32'h1000_0003);
    do_hold(1, 1, 0, 0, 1);
    chk("beq_taken", pc, 32'h20);
    do_fetch(0, 32'h0800_0004);
    do_hold(0, 0, 0, 1, 0);
    chk("jump_back", pc, 32'h10);
    do_fetch(0, 32'h1000_0003);
    do_hold(0, 1, 0, 0, 0);
    chk("beq_not_taken", pc, 32'h14);
    do_fetch(0, 32'h0800_0004);
    do_hold(0, 0, 0, 1, 0);
    do_fetch(0, 32'h1400_FFFF);
    do_hold(0, 0, 1, 0, 0);
    chk("bne_backward", pc, 32'h10);

    // Reach the top of the address space and wrap sequentially.
    do_fetch(0, 32'h0800_0000);
    do_hold(0, 0, 0, 1, 0);
    chk("jump_zero", pc, 32'h0);
    do_fetch(0, 32'h1000_FFFE);
    do_hold(0, 1, 0, 0, 1);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pcplus4", pcplus4, 32'h0);
    do_fetch(2, 32'h0123_4567);
    do_hold(3, 0, 0, 0, 0);
    chk("wrap_next", pc, 32'h0);

    // Reset during FETCH with a late response in the first post-reset cycle.
    chk("mid_req", imem_req, 1);
    reset_dut(1);
    @(negedge clk);
    idle_inputs(0);
    chk("late_instr", instr, 32'h0);
    chk("late_req", imem_req, 1);
    chk("late_addr", imem_addr, 32'h0);
    do_fetch(0, 32'h2008_0005);
    do_hold(0, 0, 0, 0, 0);

    for (int k = 0; k < 300; k++) begin
      w = $urandom;
      if ($urandom_range(0, 3) == 0) w = {6'h04, 10'($urandom), 16'($urandom_range(0, 64) - 32)};
      do_fetch($urandom_range(0, 3), w);
      do_hold($urandom_range(0, 2), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 3) == 0), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
